mult_axis_pipe: RTL and testbench
=================================

MULT_AXIS_PIPE -- requirements
Module: mult_axis_pipe

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter A_WIDTH, default 16: operand A width, legal range 2..64.
REQ-002 The block SHALL have parameter B_WIDTH, default 16: operand B width, legal range 2..64.
REQ-003 The block SHALL have parameter STAGES, default 3: pipeline depth, legal range 1..8.
REQ-004 The block SHALL have parameter SIGNED, default 0: 0 selects unsigned multiply, 1 selects two's-complement multiply.
REQ-005 The block SHALL have parameter USER_WIDTH, default 1: width of the sideband tag carried with each beat.
Ports (name, direction, width, meaning):
REQ-006 clk, in, 1: the single clock; all state updates on its rising edge.
REQ-007 rst, in, 1: reset, asynchronous and active-low.
REQ-008 input_a_tdata, in, A_WIDTH: operand A; input_a_tvalid, in, 1; input_a_tready, out, 1.
REQ-009 input_a_tuser, in, USER_WIDTH: tag, captured together with operand A.
REQ-010 input_b_tdata, in, B_WIDTH: operand B; input_b_tvalid, in, 1; input_b_tready, out, 1.
REQ-011 output_tdata, out, A_WIDTH+B_WIDTH: product; output_tuser, out, USER_WIDTH; output_tvalid, out, 1; output_tready, in, 1.
REQ-012 occupancy, out, clog2(STAGES+1): number of pipeline stages currently holding a valid beat.

Function
REQ-013 Each pipeline stage k (0..STAGES-1) SHALL hold a valid bit v[k], a data field and a user field.
REQ-014 Stage ready SHALL be defined as rdy[k] = !v[k] | rdy[k+1], with rdy[STAGES] = output_tready.
REQ-015 Outputs SHALL be input_a_tready = input_b_tvalid & rdy[0] and input_b_tready = input_a_tvalid & rdy[0]; a channel's tready SHALL NOT depend combinationally on that channel's own tvalid.
REQ-016 A beat SHALL be accepted only when input_a_tvalid, input_b_tvalid and rdy[0] are all 1 in the same cycle; neither operand SHALL be consumed alone.
REQ-017 Stage k SHALL load from stage k-1 (stage 0 from the inputs) whenever rdy[k] = 1; v[k] SHALL take the upstream valid value, so bubbles collapse.
REQ-018 A stage with rdy[k] = 0 SHALL hold its data, user and valid contents unchanged.
REQ-019 Signals output_tvalid, output_tdata and output_tuser SHALL be driven directly from the last stage's registers.
REQ-020 While output_tvalid = 1 and output_tready = 0, output_tdata and output_tuser SHALL remain stable.
REQ-021 The product SHALL be the full A_WIDTH+B_WIDTH-bit result with no truncation.
REQ-022 When SIGNED = 1, both operands SHALL be treated as two's complement and the result SHALL be sign-extended to the full width.
REQ-023 The multiply MAY be placed in any stage or split across stages, provided REQ-021 and REQ-022 are met.
REQ-024 Latency: a beat accepted in cycle c SHALL present output_tvalid = 1 in cycle c+STAGES when the pipeline is empty and output_tready = 1.
REQ-025 Throughput SHALL be one beat per cycle while output_tready = 1 and both inputs are valid.
REQ-026 Beats SHALL leave in acceptance order, with each tag paired to its own product.
REQ-027 A full pipeline whose output is taken in the same cycle (output_tready = 1) SHALL accept a new beat in that cycle.
REQ-028 occupancy SHALL equal the count of set v[k] bits, updated on every edge.

Reset
REQ-029 Asserting rst low SHALL asynchronously clear all v[k], all data fields and all user fields to 0, discarding in-flight beats.
REQ-030 While rst is low: output_tvalid = 0, output_tdata = 0, output_tuser = 0, occupancy = 0, and input_a_tready = input_b_tready = 0.
REQ-031 After rst deasserts, the first rising edge SHALL be able to accept a beat.

Verification
REQ-032 Unsigned latency check: A=B=16, STAGES=3, SIGNED=0, input 0xFFFF x 0xFFFF with tag 1, output_tready=1 -> output_tdata = 0xFFFE0001, tag 1, valid in cycle c+3.
REQ-033 Signed arithmetic check: SIGNED=1, input 0xFFFF x 0x0002 -> output_tdata = 0xFFFFFFFE; input 0x8000 x 0x8000 -> output_tdata = 0x40000000.
REQ-034 Backpressure check: hold output_tready=0 and stream 2x3, 4x5, 6x7, 8x9 -> occupancy reaches 3, both input treadys drop to 0, output_tdata holds 6; then release -> outputs 6, 20, 42, 72 in order with no loss.
REQ-035 Join check: assert only input_a_tvalid for 5 cycles -> input_b_tready = 1, input_a_tready = 0, no acceptance, occupancy stays 0; then raise input_b_tvalid -> exactly one acceptance.
REQ-036 Bubble collapse check: send 3x3, idle 1 cycle, send 4x4 with output_tready=0 -> occupancy = 2, stored in adjacent stages; then release -> 9 then 16 in consecutive cycles.
REQ-037 Mid-operation reset check: pulse rst low asynchronously (not edge-aligned) with 3 beats in flight -> outputs 0 immediately, no stale beat appears after release, and the next beat 5x5 yields 25.

Source files
------------

// File: rtl/mult_axis_pipe_if.sv
// Stream bundle for mult_axis_pipe: two operand channels joined into one product channel.
// The slave modport is the multiplier's view; master is the producer/consumer side.
interface mult_axis_pipe_if #(
   parameter int unsigned A_WIDTH    = 16,
   parameter int unsigned B_WIDTH    = 16,
   parameter int unsigned USER_WIDTH = 1
);
   logic [A_WIDTH-1:0]         input_a_tdata;
   logic [USER_WIDTH-1:0]      input_a_tuser;
   logic                       input_a_tvalid;
   logic                       input_a_tready;
   logic [B_WIDTH-1:0]         input_b_tdata;
   logic                       input_b_tvalid;
   logic                       input_b_tready;
   logic [A_WIDTH+B_WIDTH-1:0] output_tdata;
   logic [USER_WIDTH-1:0]      output_tuser;
   logic                       output_tvalid;
   logic                       output_tready;

   modport slave (
      input  input_a_tdata, input_a_tuser, input_a_tvalid,
      input  input_b_tdata, input_b_tvalid,
      input  output_tready,
      output input_a_tready, input_b_tready,
      output output_tdata, output_tuser, output_tvalid
   );

   modport master (
      output input_a_tdata, input_a_tuser, input_a_tvalid,
      output input_b_tdata, input_b_tvalid,
      output output_tready,
      input  input_a_tready, input_b_tready,
      input  output_tdata, output_tuser, output_tvalid
   );
endinterface

// File: rtl/mult_axis_pipe.sv
// Pipelined multiplier joining two operand streams; multiply happens in front of stage 0 and
// the product rides a STAGES-deep elastic register chain with per-stage ready.
module mult_axis_pipe #(
   parameter int unsigned A_WIDTH    = 16,
   parameter int unsigned B_WIDTH    = 16,
   parameter int unsigned STAGES     = 3,
   parameter bit          SIGNED     = 1'b0,
   parameter int unsigned USER_WIDTH = 1,
   localparam int unsigned P_WIDTH   = A_WIDTH + B_WIDTH,
   localparam int unsigned OCC_WIDTH = $clog2(STAGES + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   mult_axis_pipe_if.slave      bus,
   output logic [OCC_WIDTH-1:0] occupancy
);

   logic [STAGES-1:0]     v_q, v_d;
   logic [P_WIDTH-1:0]    data_q [STAGES];
   logic [P_WIDTH-1:0]    data_d [STAGES];
   logic [USER_WIDTH-1:0] user_q [STAGES];
   logic [USER_WIDTH-1:0] user_d [STAGES];
   logic [STAGES:0]       rdy;
   logic                  accept;
   logic [P_WIDTH-1:0]    a_ext, b_ext, product;

   // Extending both operands to the full result width first makes the low P_WIDTH bits of the
   // product exact for either signedness.
   always_comb begin
      if (SIGNED) begin
         a_ext = P_WIDTH'($signed(bus.input_a_tdata));
         b_ext = P_WIDTH'($signed(bus.input_b_tdata));
      end else begin
         a_ext = P_WIDTH'(bus.input_a_tdata);
         b_ext = P_WIDTH'(bus.input_b_tdata);
      end
      product = a_ext * b_ext;
   end

   always_comb begin
      logic r;
      r           = bus.output_tready;
      rdy         = '0;
      rdy[STAGES] = r;
      for (int k = STAGES - 1; k >= 0; k--) begin
         r      = ~v_q[k] | r;
         rdy[k] = r;
      end
   end

   // Readies are gated by reset so nothing looks acceptable while the pipe is held clear.
   assign accept             = bus.input_a_tvalid & bus.input_b_tvalid & rdy[0] & rst;
   assign bus.input_a_tready = bus.input_b_tvalid & rdy[0] & rst;
   assign bus.input_b_tready = bus.input_a_tvalid & rdy[0] & rst;

   always_comb begin
      v_d    = v_q;
      data_d = data_q;
      user_d = user_q;
      if (rdy[0]) begin
         v_d[0]    = accept;
         data_d[0] = product;
         user_d[0] = bus.input_a_tuser;
      end
      for (int k = 1; k < STAGES; k++) begin
         if (rdy[k]) begin
            v_d[k]    = v_q[k-1];
            data_d[k] = data_q[k-1];
            user_d[k] = user_q[k-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v_q    <= '0;
         data_q <= '{default: '0};
         user_q <= '{default: '0};
      end else begin
         v_q    <= v_d;
         data_q <= data_d;
         user_q <= user_d;
      end
   end

   assign bus.output_tvalid = v_q[STAGES-1];
   assign bus.output_tdata  = data_q[STAGES-1];
   assign bus.output_tuser  = user_q[STAGES-1];

   always_comb begin
      occupancy = '0;
      for (int k = 0; k < STAGES; k++) begin
         occupancy = occupancy + OCC_WIDTH'(v_q[k]);
      end
   end

endmodule

// File: tb/tb_mult_axis_pipe.sv
// Bench for mult_axis_pipe: unsigned and signed instances share one stimulus stream and are
// checked against a queue of accepted operands evaluated with plain arithmetic.
module tb_mult_axis_pipe;
   localparam int unsigned AW = 16;
   localparam int unsigned BW = 16;
   localparam int unsigned ST = 3;
   localparam int unsigned UW = 1;
   localparam int unsigned PW = AW + BW;
   localparam int unsigned OW = $clog2(ST + 1);

   typedef struct packed {
      logic [AW-1:0] a;
      logic [BW-1:0] b;
      logic [UW-1:0] u;
   } beat_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   mult_axis_pipe_if #(.A_WIDTH(AW), .B_WIDTH(BW), .USER_WIDTH(UW)) u_if ();
   mult_axis_pipe_if #(.A_WIDTH(AW), .B_WIDTH(BW), .USER_WIDTH(UW)) s_if ();
   logic [OW-1:0] occ_u, occ_s;

   mult_axis_pipe #(
      .A_WIDTH(AW), .B_WIDTH(BW), .STAGES(ST), .SIGNED(1'b0), .USER_WIDTH(UW)
   ) u_dut (
      .clk(clk), .rst(rst), .bus(u_if.slave), .occupancy(occ_u)
   );

   mult_axis_pipe #(
      .A_WIDTH(AW), .B_WIDTH(BW), .STAGES(ST), .SIGNED(1'b1), .USER_WIDTH(UW)
   ) s_dut (
      .clk(clk), .rst(rst), .bus(s_if.slave), .occupancy(occ_s)
   );

   assign s_if.input_a_tdata  = u_if.input_a_tdata;
   assign s_if.input_a_tuser  = u_if.input_a_tuser;
   assign s_if.input_a_tvalid = u_if.input_a_tvalid;
   assign s_if.input_b_tdata  = u_if.input_b_tdata;
   assign s_if.input_b_tvalid = u_if.input_b_tvalid;
   assign s_if.output_tready  = u_if.output_tready;

   int    n_tests = 0;
   int    n_fail  = 0;
   int    n_acc   = 0;
   beat_t exp_q[$];
   beat_t mon_e;
   logic  rnd_rdy = 1'b0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [PW-1:0] ref_u(input logic [AW-1:0] a, input logic [BW-1:0] b);
      longint ua, ub;
      ua = longint'(a);
      ub = longint'(b);
      return PW'(ua * ub);
   endfunction

   function automatic logic [PW-1:0] ref_s(input logic [AW-1:0] a, input logic [BW-1:0] b);
      longint sa, sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return PW'(sa * sb);
   endfunction

   // Scoreboard and output-hold monitor, sampled on the falling edge.
   logic [PW-1:0] prev_data;
   logic [UW-1:0] prev_user;
   logic          prev_stall = 1'b0;
   always @(negedge clk) begin
      if (rst) begin
         if (prev_stall) begin
            check("hold_data", 64'(u_if.output_tdata), 64'(prev_data));
            check("hold_user", 64'(u_if.output_tuser), 64'(prev_user));
         end
         if (u_if.output_tvalid && u_if.output_tready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_out", 64'd1, 64'd0);
            end else begin
               mon_e = exp_q.pop_front();
               check("prod_u", 64'(u_if.output_tdata), 64'(ref_u(mon_e.a, mon_e.b)));
               check("user_u", 64'(u_if.output_tuser), 64'(mon_e.u));
               check("valid_s", 64'(s_if.output_tvalid), 64'd1);
               check("prod_s", 64'(s_if.output_tdata), 64'(ref_s(mon_e.a, mon_e.b)));
               check("user_s", 64'(s_if.output_tuser), 64'(mon_e.u));
            end
         end
         if (u_if.input_a_tvalid && u_if.input_b_tvalid && u_if.input_a_tready) begin
            mon_e.a = u_if.input_a_tdata;
            mon_e.b = u_if.input_b_tdata;
            mon_e.u = u_if.input_a_tuser;
            exp_q.push_back(mon_e);
            n_acc++;
         end
         prev_stall = u_if.output_tvalid && !u_if.output_tready;
         prev_data  = u_if.output_tdata;
         prev_user  = u_if.output_tuser;
      end else begin
         prev_stall = 1'b0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (rnd_rdy) u_if.output_tready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic send(input logic [AW-1:0] a, input logic [BW-1:0] b, input logic [UW-1:0] u,
                       output int waits);
      logic acc;
      u_if.input_a_tdata  = a;
      u_if.input_a_tuser  = u;
      u_if.input_b_tdata  = b;
      u_if.input_a_tvalid = 1'b1;
      u_if.input_b_tvalid = 1'b1;
      acc   = 1'b0;
      waits = 0;
      for (int i = 0; i < 100 && !acc; i++) begin
         @(negedge clk);
         acc = u_if.input_a_tready;
         tick();
         if (!acc) waits++;
      end
      if (!acc) check("send_timeout", 64'd0, 64'd1);
      u_if.input_a_tvalid = 1'b0;
      u_if.input_b_tvalid = 1'b0;
   endtask

   task automatic drain();
      u_if.output_tready = 1'b1;
      for (int i = 0; i < 50 && (occ_u != 0 || exp_q.size() != 0); i++) tick();
      check("drain_occ", 64'(occ_u), 64'd0);
      check("drain_queue", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      int w;
      int n0;
      u_if.input_a_tdata  = '0;
      u_if.input_a_tuser  = '0;
      u_if.input_b_tdata  = '0;
      u_if.input_a_tvalid = 1'b1;
      u_if.input_b_tvalid = 1'b1;
      u_if.output_tready  = 1'b1;

      // Reset state with both inputs offered.
      #3;
      check("rst_valid", 64'(u_if.output_tvalid), 64'd0);
      check("rst_data", 64'(u_if.output_tdata), 64'd0);
      check("rst_user", 64'(u_if.output_tuser), 64'd0);
      check("rst_occ", 64'(occ_u), 64'd0);
      check("rst_a_ready", 64'(u_if.input_a_tready), 64'd0);
      check("rst_b_ready", 64'(u_if.input_b_tready), 64'd0);
      u_if.input_a_tvalid = 1'b0;
      u_if.input_b_tvalid = 1'b0;
      tick();
      tick();
      rst = 1'b1;

      // Unsigned latency; first edge after reset accepts.
      send(16'hFFFF, 16'hFFFF, 1'b1, w);
      check("first_edge_accept", 64'(w), 64'd0);
      check("lat_c1", 64'(u_if.output_tvalid), 64'd0);
      tick();
      check("lat_c2", 64'(u_if.output_tvalid), 64'd0);
      tick();
      check("lat_c3_valid", 64'(u_if.output_tvalid), 64'd1);
      check("lat_c3_data", 64'(u_if.output_tdata), 64'hFFFE0001);
      check("lat_c3_user", 64'(u_if.output_tuser), 64'd1);

      // Signed results.
      send(16'hFFFF, 16'h0002, 1'b0, w);
      tick();
      tick();
      check("signed_neg", 64'(s_if.output_tdata), 64'hFFFFFFFE);
      send(16'h8000, 16'h8000, 1'b1, w);
      tick();
      tick();
      check("signed_min", 64'(s_if.output_tdata), 64'h40000000);
      drain();

      // Backpressure.
      u_if.output_tready = 1'b0;
      send(16'd2, 16'd3, 1'b0, w);
      send(16'd4, 16'd5, 1'b1, w);
      send(16'd6, 16'd7, 1'b0, w);
      u_if.input_a_tdata  = 16'd8;
      u_if.input_b_tdata  = 16'd9;
      u_if.input_a_tuser  = 1'b1;
      u_if.input_a_tvalid = 1'b1;
      u_if.input_b_tvalid = 1'b1;
      #1;
      check("bp_occ", 64'(occ_u), 64'd3);
      check("bp_a_ready", 64'(u_if.input_a_tready), 64'd0);
      check("bp_b_ready", 64'(u_if.input_b_tready), 64'd0);
      check("bp_data", 64'(u_if.output_tdata), 64'd6);
      tick();
      check("bp_hold", 64'(u_if.output_tdata), 64'd6);
      u_if.output_tready = 1'b1;
      #1;
      check("full_take_ready", 64'(u_if.input_a_tready), 64'd1);
      send(16'd8, 16'd9, 1'b1, w);
      drain();

      // Join: A alone must not be consumed.
      n0 = n_acc;
      u_if.input_a_tdata  = 16'd7;
      u_if.input_a_tvalid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("join_b_ready", 64'(u_if.input_b_tready), 64'd1);
         check("join_a_ready", 64'(u_if.input_a_tready), 64'd0);
         tick();
      end
      check("join_occ", 64'(occ_u), 64'd0);
      check("join_none", 64'(n_acc - n0), 64'd0);
      send(16'd7, 16'd11, 1'b1, w);
      tick();
      tick();
      check("join_one", 64'(n_acc - n0), 64'd1);
      drain();

      // Bubble collapse.
      u_if.output_tready = 1'b0;
      send(16'd3, 16'd3, 1'b0, w);
      tick();
      send(16'd4, 16'd4, 1'b1, w);
      tick();
      check("bub_occ", 64'(occ_u), 64'd2);
      check("bub_first", 64'(u_if.output_tdata), 64'd9);
      u_if.output_tready = 1'b1;
      tick();
      check("bub_second_valid", 64'(u_if.output_tvalid), 64'd1);
      check("bub_second", 64'(u_if.output_tdata), 64'd16);
      tick();
      check("bub_empty", 64'(u_if.output_tvalid), 64'd0);
      drain();

      // Randomized traffic with random output stalls.
      rnd_rdy = 1'b1;
      for (int i = 0; i < 300; i++) begin
         repeat ($urandom_range(0, 2)) tick();
         send(AW'($urandom), BW'($urandom), UW'($urandom), w);
      end
      rnd_rdy = 1'b0;
      drain();

      // Asynchronous reset mid-flight.
      send(16'd1, 16'd2, 1'b1, w);
      send(16'd3, 16'd4, 1'b0, w);
      send(16'd5, 16'd6, 1'b1, w);
      u_if.input_a_tvalid = 1'b1;
      u_if.input_b_tvalid = 1'b1;
      #2;
      rst = 1'b0;
      exp_q.delete();
      #1;
      check("mrst_valid", 64'(u_if.output_tvalid), 64'd0);
      check("mrst_data", 64'(u_if.output_tdata), 64'd0);
      check("mrst_user", 64'(u_if.output_tuser), 64'd0);
      check("mrst_occ", 64'(occ_u), 64'd0);
      check("mrst_a_ready", 64'(u_if.input_a_tready), 64'd0);
      u_if.input_a_tvalid = 1'b0;
      u_if.input_b_tvalid = 1'b0;
      #3;
      rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("mrst_no_stale", 64'(u_if.output_tvalid), 64'd0);
      end
      send(16'd5, 16'd5, 1'b0, w);
      tick();
      tick();
      check("mrst_next", 64'(u_if.output_tdata), 64'd25);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
